// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that time-shares one external 32-bit
// ripple adder between NUM_REQ requesters. A granted request is latched into
// operand registers (p0), the adder result is captured into the response
// registers one cycle later and held on a valid/ready response channel.
// Optional build macro ADDER_ARB_SUB_EN adds a per-requester req_sub input
// that turns the operation into a - b (B inverted, carry-in forced to 1).
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]    req_sub,
`endif
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int DATA_W = 32;
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     win;
  logic                any_valid;
  logic                grant_ok;
  logic [ID_W:0]       cand_ext;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_cin;

  logic [DATA_W-1:0]   op_a_p0;
  logic [DATA_W-1:0]   op_b_p0;
  logic                op_cin_p0;
  logic [ID_W-1:0]     op_id_p0;

  // Signed overflow of a + b giving s: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Round-robin search from last_grant+1; descending scan leaves the nearest valid requester.
  always_comb begin
    win       = last_grant;
    any_valid = 1'b0;
    cand_ext  = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_ext = {1'b0, last_grant} + (ID_W+1)'(i);
      if (cand_ext >= NUM_REQ_W) cand_ext = cand_ext - NUM_REQ_W;
      cand = cand_ext[ID_W-1:0];
      if (req_valid[cand]) begin
        win       = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Grant is offered only when the operand registers are free to reload; held off in reset.
  always_comb begin
    grant_ok  = rst_n && any_valid &&
                ((state == IDLE) || ((state == RESP) && rsp_ready));
    req_ready = '0;
    if (grant_ok) req_ready[win] = 1'b1;
  end

  // Winner's operands as they will be latched; subtract inverts B and forces carry-in.
  always_comb begin
    sel_a   = req_a[{win, 5'd0} +: DATA_W];
    sel_b   = req_b[{win, 5'd0} +: DATA_W];
    sel_cin = req_cin[win];
`ifdef ADDER_ARB_SUB_EN
    if (req_sub[win]) begin
      sel_b   = ~req_b[{win, 5'd0} +: DATA_W];
      sel_cin = 1'b1;
    end
`endif
  end

  // p0: operand registers feed the shared adder directly, also while idle.
  assign add_a   = op_a_p0;
  assign add_b   = op_b_p0;
  assign add_cin = op_cin_p0;

  // Sequencer FSM: latch on handshake, capture adder result in EXEC, hold in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      op_a_p0    <= '0;
      op_b_p0    <= '0;
      op_cin_p0  <= 1'b0;
      op_id_p0   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      if (grant_ok) begin
        op_a_p0    <= sel_a;
        op_b_p0    <= sel_b;
        op_cin_p0  <= sel_cin;
        op_id_p0   <= win;
        last_grant <= win;
      end
      case (state)
        IDLE: begin
          if (grant_ok) state <= EXEC;
        end
        EXEC: begin
          // p0 -> response: adder output is captured here
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_ovf   <= add_ovf(op_a_p0, op_b_p0, add_sum);
          rsp_id    <= op_id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= grant_ok ? EXEC : IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (NUM_REQ=4). The shared adder is a
// plain 33-bit addition in the bench. Define ADDER_ARB_SUB_EN to also run
// the subtract vectors.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;
`ifdef ADDER_ARB_SUB_EN
  logic [NUM_REQ-1:0]    req_sub;
`endif
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic                  add_cin;
  logic [31:0]           add_sum;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ovf;

  logic [32:0]           add_full;

  int tests = 0;
  int fails = 0;

  // hand-computed operand/result table per requester
  logic [31:0] op_a_t [NUM_REQ] = '{32'h7FFF_FFFF, 32'h0000_0010, 32'h0000_0005, 32'hFFFF_FFFF};
  logic [31:0] op_b_t [NUM_REQ] = '{32'h0000_0001, 32'h0000_0020, 32'h0000_0003, 32'h0000_0001};
  logic        cin_t  [NUM_REQ] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] sum_t  [NUM_REQ] = '{32'h8000_0000, 32'h0000_0031, 32'h0000_0009, 32'h0000_0000};
  logic        cout_t [NUM_REQ] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic        ovf_t  [NUM_REQ] = '{1'b1, 1'b0, 1'b0, 1'b0};

  int order1 [4] = '{3, 0, 1, 2};
  int order2 [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
  assign add_sum  = add_full[31:0];
  assign add_cout = add_full[32];

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a_t[i];
      req_b[32*i +: 32] = op_b_t[i];
      req_cin[i]        = cin_t[i];
    end
  endtask

  // one grant -> EXEC -> RESP round for requester g, all requesters valid
  task automatic round(input int g);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    check($sformatf("grant_%0d", g), 64'(req_ready), 64'(oh));
    tick();
    check($sformatf("exec_ready_%0d", g), 64'(req_ready), 64'd0);
    check($sformatf("exec_valid_%0d", g), 64'(rsp_valid), 64'd0);
    check($sformatf("exec_add_a_%0d", g), 64'(add_a), 64'(op_a_t[g]));
    tick();
    check($sformatf("resp_valid_%0d", g), 64'(rsp_valid), 64'd1);
    check($sformatf("resp_id_%0d", g), 64'(rsp_id), 64'(g));
    check($sformatf("resp_sum_%0d", g), 64'(rsp_sum), 64'(sum_t[g]));
    check($sformatf("resp_cout_%0d", g), 64'(rsp_cout), 64'(cout_t[g]));
    check($sformatf("resp_ovf_%0d", g), 64'(rsp_ovf), 64'(ovf_t[g]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub   = '0;
`endif
    rsp_ready = 1'b0;
    tick();
    tick();
    // reset state, requests already pending must not be granted
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    check("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);

    // single requester 2: 5 + 3 + 1
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    load_table();
    #1;
    check("t1_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    check("t1_exec_valid", 64'(rsp_valid), 64'd0);
    check("t1_add_a", 64'(add_a), 64'h5);
    check("t1_add_b", 64'(add_b), 64'h3);
    check("t1_add_cin", 64'(add_cin), 64'd1);
    tick();
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_id", 64'(rsp_id), 64'd2);
    check("t1_sum", 64'(rsp_sum), 64'h9);
    check("t1_cout", 64'(rsp_cout), 64'd0);
    check("t1_ovf", 64'(rsp_ovf), 64'd0);

    // backpressure: all requesters pending, response held for 5 cycles
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_id", 64'(rsp_id), 64'd2);
      check("bp_sum", 64'(rsp_sum), 64'h9);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end

    // release: rotation continues from last grant 2
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) round(order1[k]);

    // only requester 1 valid, reset while it executes
    req_valid = 4'b0010;
    #1;
    check("pre_rst_grant", 64'(req_ready), 64'b0010);
    tick();
    check("exec_before_rst", 64'(rsp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_sum", 64'(rsp_sum), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_add_a", 64'(add_a), 64'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) round(order2[k]);

`ifdef ADDER_ARB_SUB_EN
    // subtract: requester 0 computes 10 - 3, requester 1 computes 3 - 10
    req_valid = 4'b0001;
    req_a[31:0]  = 32'd10;
    req_b[31:0]  = 32'd3;
    req_cin[0]   = 1'b0;
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd10;
    req_cin[1]   = 1'b0;
    req_sub      = 4'b0011;
    #1;
    check("sub1_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    check("sub1_add_b", 64'(add_b), 64'hFFFF_FFFC);
    check("sub1_add_cin", 64'(add_cin), 64'd1);
    tick();
    check("sub1_sum", 64'(rsp_sum), 64'd7);
    check("sub1_cout", 64'(rsp_cout), 64'd1);
    check("sub1_ovf", 64'(rsp_ovf), 64'd0);
    req_valid = 4'b0010;
    #1;
    check("sub2_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    check("sub2_sum", 64'(rsp_sum), 64'hFFFF_FFF9);
    check("sub2_cout", 64'(rsp_cout), 64'd0);
    check("sub2_ovf", 64'(rsp_ovf), 64'd0);
    check("sub2_id", 64'(rsp_id), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
